// File: rtl/i2s_pkg.sv
// i2s_pkg -- definitions shared by the I2S receive and transmit paths.
//
// Contents:
//   I2S_DEFAULT_SIZE : default audio word width per channel, in bits
//   i2s_state_t      : word-framing state (SYNC, LEFT, RIGHT)
package i2s_pkg;

    localparam int I2S_DEFAULT_SIZE = 16;

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } i2s_state_t;

endpackage

// File: rtl/i2s_pin_sync.sv
// i2s_pin_sync -- brings the codec-driven I2S pins into the Clk domain.
//
// Each pin passes through a two-flop synchronizer. A third register holds a
// delayed copy of the synchronized SClk, and that copy drives the rising-edge
// detector. LRClk and SD get a matching third stage, so the values presented
// with bit_stb are the ones present at the SClk rising edge.
//
// Ports:
//   Clk      in  system clock
//   Reset    in  synchronous, active-high reset; clears every stage
//   SClk     in  codec bit clock (asynchronous)
//   LRClk    in  codec word select (asynchronous)
//   SD       in  codec serial data (asynchronous)
//   lrclk_s  out synchronized word select, aligned with bit_stb
//   sd_s     out synchronized serial data, aligned with bit_stb
//   bit_stb  out one-Clk strobe, high 3 Clk cycles after an SClk rising edge
module i2s_pin_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic SClk,
    input  logic LRClk,
    input  logic SD,
    output logic lrclk_s,
    output logic sd_s,
    output logic bit_stb
);

    logic sclk_p0, sclk_p1, sclk_p2;
    logic lr_p0, lr_p1;
    logic sd_p0, sd_p1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sclk_p0 <= 1'b0;
            sclk_p1 <= 1'b0;
            sclk_p2 <= 1'b0;
            lr_p0   <= 1'b0;
            lr_p1   <= 1'b0;
            lrclk_s <= 1'b0;
            sd_p0   <= 1'b0;
            sd_p1   <= 1'b0;
            sd_s    <= 1'b0;
            bit_stb <= 1'b0;
        end else begin
            // p0 -> p1: two-flop synchronizer
            sclk_p0 <= SClk;
            sclk_p1 <= sclk_p0;
            lr_p0   <= LRClk;
            lr_p1   <= lr_p0;
            sd_p0   <= SD;
            sd_p1   <= sd_p0;
            // p2: delayed copy for edge detection, data stages kept in step
            sclk_p2 <= sclk_p1;
            lrclk_s <= lr_p1;
            sd_s    <= sd_p1;
            bit_stb <= sclk_p1 & ~sclk_p2;
        end
    end

endmodule

// File: rtl/i2s_rcv.sv
// i2s_rcv -- I2S receiver for the codec ADC path (codec is clock master).
//
// The receiver deserialises left/right words on the SClk rising edges and
// presents each complete stereo frame as a parallel pair through a
// valid/ready handshake. Words longer than SIZE are truncated, with the LSBs
// dropped. Shorter words are MSB-aligned and zero-filled.
//
// Optional build macro I2S_RCV_PEAK_EN adds a peak magnitude meter. Without
// the macro, peak reads 0 and peak_clr is ignored.
//
// Parameters:
//   SIZE          output word width per channel
// Ports:
//   Clk           system clock (MAX10_CLK1_50)
//   Reset         synchronous, active-high reset
//   SClk          codec bit clock (asynchronous)
//   LRClk         codec word select, 0 = left, 1 = right (asynchronous)
//   SD            codec serial ADC data (asynchronous)
//   data_left     last complete left word, two's complement
//   data_right    last complete right word, two's complement
//   sample_valid  frame pair available
//   sample_ready  consumer accepts the pair
//   overrun       sticky: a frame that was not accepted got overwritten
//   overrun_clr   clears overrun (a simultaneous overrun event wins)
//   peak          peak magnitude over both channels since the last peak_clr
//   peak_clr      clears peak
module i2s_rcv
    import i2s_pkg::*;
#(
    parameter int SIZE = I2S_DEFAULT_SIZE
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            SClk,
    input  logic            LRClk,
    input  logic            SD,
    output logic [SIZE-1:0] data_left,
    output logic [SIZE-1:0] data_right,
    output logic            sample_valid,
    input  logic            sample_ready,
    output logic            overrun,
    input  logic            overrun_clr,
    output logic [SIZE-1:0] peak,
    input  logic            peak_clr
);

    localparam int              CNT_W   = $clog2(SIZE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SIZE);

    logic             lrclk_s;
    logic             sd_s;
    logic             bit_stb;

    i2s_state_t       state, state_nxt;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [SIZE-1:0]  shift_word, shift_nxt;
    logic [SIZE-1:0]  word_cur;
    logic [SIZE-1:0]  left_hold;
    logic             lr_prev;
    logic             latch_left;
    logic             commit;

    // Places one serial bit at its MSB-first position. A count at or past
    // SIZE matches no position, so extra LSBs of long words are dropped.
    function automatic logic [SIZE-1:0] put_bit(input logic [SIZE-1:0]  w,
                                                input logic [CNT_W-1:0] cnt,
                                                input logic             b);
        logic [SIZE-1:0] r;
        r = w;
        for (int i = 0; i < SIZE; i++) begin
            if (cnt == CNT_W'(SIZE - 1 - i)) begin
                r[i] = b;
            end
        end
        return r;
    endfunction

    i2s_pin_sync u_pin_sync (
        .Clk     (Clk),
        .Reset   (Reset),
        .SClk    (SClk),
        .LRClk   (LRClk),
        .SD      (SD),
        .lrclk_s (lrclk_s),
        .sd_s    (sd_s),
        .bit_stb (bit_stb)
    );

    // The current word with the bit now on SD included. On an LRClk change
    // this is the finished word, because I2S delays the data by one bit and
    // the LSB slot arrives together with the new word-select level.
    assign word_cur = put_bit(shift_word, bit_cnt, sd_s);

    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift_word;
        latch_left  = 1'b0;
        commit      = 1'b0;
        if (bit_stb) begin
            case (state)
                SYNC: begin
                    if (lr_prev && !lrclk_s) begin
                        state_nxt   = LEFT;
                        bit_cnt_nxt = '0;
                        shift_nxt   = '0;
                    end
                end
                LEFT: begin
                    if (lr_prev) begin
                        // Word select does not agree with the channel: drop the frame.
                        state_nxt   = SYNC;
                        bit_cnt_nxt = '0;
                    end else if (lrclk_s) begin
                        latch_left  = 1'b1;
                        state_nxt   = RIGHT;
                        bit_cnt_nxt = '0;
                        shift_nxt   = '0;
                    end else begin
                        shift_nxt = word_cur;
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                RIGHT: begin
                    if (!lr_prev) begin
                        state_nxt   = SYNC;
                        bit_cnt_nxt = '0;
                    end else if (!lrclk_s) begin
                        commit      = 1'b1;
                        state_nxt   = LEFT;
                        bit_cnt_nxt = '0;
                        shift_nxt   = '0;
                    end else begin
                        shift_nxt = word_cur;
                        if (bit_cnt != CNT_MAX) begin
                            bit_cnt_nxt = bit_cnt + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_nxt   = SYNC;
                    bit_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= SYNC;
            bit_cnt <= '0;
            lr_prev <= 1'b0;
        end else begin
            state   <= state_nxt;
            bit_cnt <= bit_cnt_nxt;
            if (bit_stb) begin
                lr_prev <= lrclk_s;
            end
        end
    end

    // The shift word is cleared whenever a new word starts, so it needs no reset.
    always_ff @(posedge Clk) begin
        shift_word <= shift_nxt;
        if (latch_left) begin
            left_hold <= word_cur;
        end
    end

    // A commit reloads the pair and keeps valid high even on an accept cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            data_left    <= '0;
            data_right   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            if (commit) begin
                data_left    <= left_hold;
                data_right   <= word_cur;
                sample_valid <= 1'b1;
            end else if (sample_ready) begin
                sample_valid <= 1'b0;
            end
            if (commit && sample_valid && !sample_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef I2S_RCV_PEAK_EN
    localparam logic signed [SIZE-1:0] MOST_NEG = {1'b1, {(SIZE-1){1'b0}}};
    localparam logic        [SIZE-1:0] MAX_POS  = {1'b0, {(SIZE-1){1'b1}}};

    logic [SIZE-1:0] mag_left;
    logic [SIZE-1:0] mag_right;
    logic [SIZE-1:0] frame_max;
    logic [SIZE-1:0] peak_base;
    logic [SIZE-1:0] peak_r;

    // Absolute value. The most negative code has no positive counterpart,
    // so it saturates to the largest positive value.
    function automatic logic [SIZE-1:0] magnitude(input logic signed [SIZE-1:0] v);
        logic signed [SIZE-1:0] neg;
        if (!v[SIZE-1]) begin
            return $unsigned(v);
        end
        if (v == MOST_NEG) begin
            return MAX_POS;
        end
        neg = -v;
        return $unsigned(neg);
    endfunction

    assign mag_left  = magnitude($signed(left_hold));
    assign mag_right = magnitude($signed(word_cur));
    assign frame_max = (mag_left > mag_right) ? mag_left : mag_right;
    // When a clear and a commit coincide, the new frame is compared against 0.
    assign peak_base = peak_clr ? '0 : peak_r;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            peak_r <= '0;
        end else if (commit) begin
            peak_r <= (frame_max > peak_base) ? frame_max : peak_base;
        end else if (peak_clr) begin
            peak_r <= '0;
        end
    end

    assign peak = peak_r;
`else
    logic unused_peak_clr;

    assign unused_peak_clr = peak_clr;
    assign peak            = '0;
`endif

endmodule

// File: tb/tb_i2s_rcv.sv
// tb_i2s_rcv -- self-checking bench for i2s_rcv (SIZE = 16).
// A behavioural I2S source drives the codec pins from word values. Expected
// outputs come from plain arithmetic on those word values.
module tb_i2s_rcv;

    localparam int SIZE = 16;

    logic            Clk = 1'b0;
    logic            Reset = 1'b1;
    logic            SClk = 1'b0;
    logic            LRClk = 1'b0;
    logic            SD = 1'b0;
    logic            sample_ready = 1'b0;
    logic            overrun_clr = 1'b0;
    logic            peak_clr = 1'b0;
    logic [SIZE-1:0] data_left;
    logic [SIZE-1:0] data_right;
    logic            sample_valid;
    logic            overrun;
    logic [SIZE-1:0] peak;

    int              n_checks = 0;
    int              n_fail = 0;
    logic            carry = 1'b0;
    logic [SIZE-1:0] acc_l[$];
    logic [SIZE-1:0] acc_r[$];

    i2s_rcv #(.SIZE(SIZE)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .SClk         (SClk),
        .LRClk        (LRClk),
        .SD           (SD),
        .data_left    (data_left),
        .data_right   (data_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .overrun      (overrun),
        .overrun_clr  (overrun_clr),
        .peak         (peak),
        .peak_clr     (peak_clr)
    );

    always #10 Clk = ~Clk;

    // Record every accepted pair as the consumer sees it.
    always @(posedge Clk) begin
        if (!Reset && sample_valid && sample_ready) begin
            acc_l.push_back(data_left);
            acc_r.push_back(data_right);
        end
    end

    // Bit j of an n-bit word sent MSB first into a slot, padded with zeros.
    function automatic logic stream_bit(input logic [31:0] w, input int n, input int j);
        if (j < n) return w[n-1-j];
        return 1'b0;
    endfunction

    // The value the receiver should hold for an n-bit word.
    function automatic logic [15:0] align(input logic [31:0] w, input int n);
        logic [31:0] t;
        if (n >= 16) t = w >> (n - 16);
        else         t = w << (16 - n);
        return t[15:0];
    endfunction

    function automatic logic [15:0] mag(input logic [15:0] w);
        int v;
        v = int'($signed(w));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return 16'(v);
    endfunction

    // One SClk period of 16 Clk: the pins change while SClk is low.
    task automatic send_slot(input logic lr, input logic d);
        SClk  = 1'b0;
        LRClk = lr;
        SD    = d;
        repeat (8) @(negedge Clk);
        SClk = 1'b1;
        repeat (8) @(negedge Clk);
    endtask

    // One channel half of s slots. The data runs one slot behind LRClk.
    task automatic send_half(input logic lr, input logic [31:0] w, input int n, input int s);
        for (int k = 0; k < s; k++) begin
            send_slot(lr, (k == 0) ? carry : stream_bit(w, n, k - 1));
        end
        carry = stream_bit(w, n, s - 1);
    endtask

    // First slot of the next left half: carries the right LSB and commits.
    task automatic commit_slot();
        send_slot(1'b0, carry);
        carry = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, expected 0", sample_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        n_checks++; if (data_left !== 16'h0) begin n_fail++; $display("FAIL reset_left: got %h, expected 0000", data_left); end
        n_checks++; if (data_right !== 16'h0) begin n_fail++; $display("FAIL reset_right: got %h, expected 0000", data_right); end
        n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL reset_peak: got %h, expected 0000", peak); end
        Reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic test_frame();
        int first;
        int high;
        first = -1;
        high  = 0;
        sample_ready = 1'b1;
        send_half(1'b1, 32'hFFFF, 16, 16);
        send_half(1'b0, 32'h1234, 16, 16);
        acc_l.delete(); acc_r.delete();
        send_half(1'b1, 32'hABCD, 16, 16);
        // Commit slot driven by hand so the Clk cycles after the SClk rise can be counted.
        SClk  = 1'b0;
        LRClk = 1'b0;
        SD    = carry;
        repeat (8) @(negedge Clk);
        SClk = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(posedge Clk);
            #1;
            if (sample_valid) begin
                if (first < 0) first = i;
                high++;
            end
        end
        @(negedge Clk);
        carry = 1'b0;
        n_checks++; if (first !== 4) begin n_fail++; $display("FAIL frame_latency: got %0d, expected 4", first); end
        n_checks++; if (high !== 1) begin n_fail++; $display("FAIL frame_valid_width: got %0d, expected 1", high); end
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL frame_count: got %0d, expected 1", acc_l.size()); end
        if (acc_l.size() >= 1) begin
            n_checks++; if (acc_l[0] !== 16'h1234) begin n_fail++; $display("FAIL frame_left: got %h, expected 1234", acc_l[0]); end
            n_checks++; if (acc_r[0] !== 16'hABCD) begin n_fail++; $display("FAIL frame_right: got %h, expected abcd", acc_r[0]); end
        end
    endtask

    task automatic test_mid_right();
        logic [15:0] l;
        logic [15:0] r;
        l = 16'($urandom);
        r = 16'($urandom);
        pulse_reset();
        sample_ready = 1'b1;
        acc_l.delete(); acc_r.delete();
        for (int i = 0; i < 5; i++) send_slot(1'b1, 1'($urandom));
        send_half(1'b0, {16'h0, l}, 16, 16);
        n_checks++; if (acc_l.size() !== 0) begin n_fail++; $display("FAIL midright_early_left: got %0d frames, expected 0", acc_l.size()); end
        send_half(1'b1, {16'h0, r}, 16, 16);
        n_checks++; if (acc_l.size() !== 0) begin n_fail++; $display("FAIL midright_early_right: got %0d frames, expected 0", acc_l.size()); end
        commit_slot();
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL midright_count: got %0d, expected 1", acc_l.size()); end
        if (acc_l.size() >= 1) begin
            n_checks++; if (acc_l[0] !== l) begin n_fail++; $display("FAIL midright_left: got %h, expected %h", acc_l[0], l); end
            n_checks++; if (acc_r[0] !== r) begin n_fail++; $display("FAIL midright_right: got %h, expected %h", acc_r[0], r); end
        end
    endtask

    task automatic test_word_length();
        logic [31:0] r24;
        r24 = {8'h0, 24'($urandom)};
        sample_ready = 1'b1;
        // 24-bit words in 64-fs frames
        send_half(1'b1, 32'h0, 24, 32);
        send_half(1'b0, 32'h123456, 24, 32);
        acc_l.delete(); acc_r.delete();
        send_half(1'b1, r24, 24, 32);
        commit_slot();
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL len24_count: got %0d, expected 1", acc_l.size()); end
        if (acc_l.size() >= 1) begin
            n_checks++; if (acc_l[0] !== align(32'h123456, 24)) begin n_fail++; $display("FAIL len24_left: got %h, expected %h", acc_l[0], align(32'h123456, 24)); end
            n_checks++; if (acc_r[0] !== align(r24, 24)) begin n_fail++; $display("FAIL len24_right: got %h, expected %h", acc_r[0], align(r24, 24)); end
        end
        // 8-bit words in 16-fs frames
        send_half(1'b1, 32'h0, 8, 8);
        send_half(1'b0, 32'hC3, 8, 8);
        acc_l.delete(); acc_r.delete();
        send_half(1'b1, 32'h5A, 8, 8);
        commit_slot();
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL len8_count: got %0d, expected 1", acc_l.size()); end
        if (acc_l.size() >= 1) begin
            n_checks++; if (acc_l[0] !== align(32'hC3, 8)) begin n_fail++; $display("FAIL len8_left: got %h, expected %h", acc_l[0], align(32'hC3, 8)); end
            n_checks++; if (acc_r[0] !== 16'h5A00) begin n_fail++; $display("FAIL len8_right: got %h, expected 5a00", acc_r[0]); end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ls[6];
        logic [15:0] rs[6];
        for (int f = 0; f < 6; f++) begin
            ls[f] = 16'($urandom);
            rs[f] = 16'($urandom);
        end
        sample_ready = 1'b1;
        send_half(1'b1, 32'h0, 16, 16);
        for (int f = 0; f < 6; f++) begin
            send_half(1'b0, {16'h0, ls[f]}, 16, 16);
            if (f == 0) begin acc_l.delete(); acc_r.delete(); end
            send_half(1'b1, {16'h0, rs[f]}, 16, 16);
        end
        commit_slot();
        n_checks++; if (acc_l.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d, expected 6", acc_l.size()); end
        for (int i = 0; i < 6 && i < acc_l.size(); i++) begin
            n_checks++; if (acc_l[i] !== ls[i]) begin n_fail++; $display("FAIL b2b_left[%0d]: got %h, expected %h", i, acc_l[i], ls[i]); end
            n_checks++; if (acc_r[i] !== rs[i]) begin n_fail++; $display("FAIL b2b_right[%0d]: got %h, expected %h", i, acc_r[i], rs[i]); end
        end
    endtask

    task automatic test_overrun();
        sample_ready = 1'b1;
        send_half(1'b1, 32'h0, 16, 16);
        send_half(1'b0, 32'h1111, 16, 16);
        acc_l.delete(); acc_r.delete();
        sample_ready = 1'b0;
        send_half(1'b1, 32'h2222, 16, 16);
        send_half(1'b0, 32'h3333, 16, 16);
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_first_valid: got %b, expected 1", sample_valid); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_not_yet: got %b, expected 0", overrun); end
        n_checks++; if (data_left !== 16'h1111) begin n_fail++; $display("FAIL ovr_first_left: got %h, expected 1111", data_left); end
        send_half(1'b1, 32'h4444, 16, 16);
        commit_slot();
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b, expected 1", overrun); end
        n_checks++; if (data_left !== 16'h3333) begin n_fail++; $display("FAIL ovr_left: got %h, expected 3333", data_left); end
        n_checks++; if (data_right !== 16'h4444) begin n_fail++; $display("FAIL ovr_right: got %h, expected 4444", data_right); end
        overrun_clr = 1'b1;
        @(negedge Clk);
        overrun_clr = 1'b0;
        @(negedge Clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b, expected 0", overrun); end
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid_held: got %b, expected 1", sample_valid); end
        sample_ready = 1'b1;
        @(negedge Clk);
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_accept: got %b, expected 0", sample_valid); end
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL ovr_accept_count: got %0d, expected 1", acc_l.size()); end
    endtask

    task automatic test_reset_mid_word();
        logic [15:0] l2;
        logic [15:0] r2;
        l2 = 16'($urandom);
        r2 = 16'($urandom);
        sample_ready = 1'b0;
        send_half(1'b1, 32'h0, 16, 16);
        send_half(1'b0, 32'h5A5A, 16, 16);
        send_half(1'b1, 32'hC3C3, 16, 16);
        send_slot(1'b0, carry);
        for (int i = 0; i < 5; i++) send_slot(1'b0, 1'($urandom));
        n_checks++; if (sample_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_valid: got %b, expected 1", sample_valid); end
        pulse_reset();
        n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b, expected 0", sample_valid); end
        n_checks++; if (data_left !== 16'h0) begin n_fail++; $display("FAIL rstmid_left: got %h, expected 0000", data_left); end
        n_checks++; if (data_right !== 16'h0) begin n_fail++; $display("FAIL rstmid_right: got %h, expected 0000", data_right); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rstmid_overrun: got %b, expected 0", overrun); end
        n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL rstmid_peak: got %h, expected 0000", peak); end
        sample_ready = 1'b1;
        acc_l.delete(); acc_r.delete();
        for (int i = 0; i < 10; i++) send_slot(1'b0, 1'($urandom));
        send_half(1'b1, 32'($urandom), 16, 16);
        send_half(1'b0, {16'h0, l2}, 16, 16);
        n_checks++; if (acc_l.size() !== 0) begin n_fail++; $display("FAIL rstmid_early: got %0d frames, expected 0", acc_l.size()); end
        send_half(1'b1, {16'h0, r2}, 16, 16);
        commit_slot();
        n_checks++; if (acc_l.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d, expected 1", acc_l.size()); end
        if (acc_l.size() >= 1) begin
            n_checks++; if (acc_l[0] !== l2) begin n_fail++; $display("FAIL rstmid_data_left: got %h, expected %h", acc_l[0], l2); end
            n_checks++; if (acc_r[0] !== r2) begin n_fail++; $display("FAIL rstmid_data_right: got %h, expected %h", acc_r[0], r2); end
        end
    endtask

    task automatic test_peak();
        logic [15:0] exp_peak;
        sample_ready = 1'b1;
        peak_clr = 1'b1;
        @(negedge Clk);
        peak_clr = 1'b0;
        @(negedge Clk);
`ifdef I2S_RCV_PEAK_EN
        n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL peak_clear0: got %h, expected 0000", peak); end
`endif
        // The right half below closes a frame whose words are both zero.
        send_half(1'b1, 32'h0, 16, 16);
        send_half(1'b0, 32'h8000, 16, 16);
        send_half(1'b1, 32'h0100, 16, 16);
        commit_slot();
`ifdef I2S_RCV_PEAK_EN
        exp_peak = (mag(16'h8000) > mag(16'h0100)) ? mag(16'h8000) : mag(16'h0100);
`else
        exp_peak = 16'h0;
`endif
        n_checks++; if (peak !== exp_peak) begin n_fail++; $display("FAIL peak_most_neg: got %h, expected %h", peak, exp_peak); end
        peak_clr = 1'b1;
        @(negedge Clk);
        peak_clr = 1'b0;
        @(negedge Clk);
        n_checks++; if (peak !== 16'h0) begin n_fail++; $display("FAIL peak_clear: got %h, expected 0000", peak); end
        send_half(1'b1, 32'h0, 16, 16);
        send_half(1'b0, 32'hFF00, 16, 16);
        send_half(1'b1, 32'h0000, 16, 16);
        commit_slot();
`ifdef I2S_RCV_PEAK_EN
        exp_peak = mag(16'hFF00);
`else
        exp_peak = 16'h0;
`endif
        n_checks++; if (peak !== exp_peak) begin n_fail++; $display("FAIL peak_negative: got %h, expected %h", peak, exp_peak); end
    endtask

    initial begin
        @(negedge Clk);
        test_reset();
        test_frame();
        test_mid_right();
        test_word_length();
        test_back_to_back();
        test_overrun();
        test_reset_mid_word();
        test_peak();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
